// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller of the
// five-stage MIPS pipeline: bypass-select encodings, the Tuse "unused"
// marker and the scoreboard entry layout.
package hazard_fwd_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam int TW     = 2;
  localparam int CNT_W  = 32;

  // Bypass mux select encoding, shared by every fwd_* output.
  // 2'b11 is never produced.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  // Tuse value meaning "this operand is not read".
  localparam logic [TW-1:0] TUSE_NONE = 2'b11;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // One scoreboard entry: a pending register write.
  // tnew counts the cycles left until the result exists in the pipeline.
  typedef struct packed {
    logic            valid;
    reg_addr_t       dst;
    logic [TW-1:0]   tnew;
  } entry_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Bundle between the decode stage and the hazard/forwarding controller:
// D-stage operand/destination description in, stall and bypass selects out.
interface hazard_fwd_ctrl_if;
  import hazard_fwd_ctrl_pkg::*;

  reg_addr_t         d_rs;
  reg_addr_t         d_rt;
  logic [TW-1:0]     d_tuse_rs;
  logic [TW-1:0]     d_tuse_rt;
  reg_addr_t         d_dst;
  logic [TW-1:0]     d_tnew;

  logic              stall;
  logic [1:0]        fwd_d_rs;
  logic [1:0]        fwd_d_rt;
  logic [1:0]        fwd_e_rs;
  logic [1:0]        fwd_e_rt;
  logic [1:0]        fwd_m_rt;
  logic [CNT_W-1:0]  stall_cnt;

  // Pipeline side: describes the D instruction, consumes the decisions.
  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
  );

  // Controller side.
  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
  );

endinterface

// File: rtl/hazard_entry_reg.sv
// One scoreboard entry register. Loads the entry presented at d every
// cycle, or an all-zero bubble when requested, and optionally ages tnew by
// one with saturation at zero while it moves to the next stage.
module hazard_entry_reg
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  entry_t d,
  input  logic   bubble,
  input  logic   dec,
  output entry_t q
);

  function automatic logic [TW-1:0] tnew_dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : (t - TW'(1));
  endfunction

  // Entry flop: bubble clears every field, otherwise capture and age tnew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q.valid <= d.valid;
      q.dst   <= d.dst;
      q.tnew  <= dec ? tnew_dec_sat(d.tnew) : d.tnew;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Scoreboard-based hazard and forwarding controller. Tracks the pending
// writes of the instructions in E, M and W, stalls the D instruction when an
// operand will not be ready by its Tuse, and drives the bypass selects for
// the D compare, E ALU and M store-data muxes.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  hazard_fwd_ctrl_if.slave bus
);

  entry_t           d_ent;
  entry_t           ent_e_p0;
  entry_t           ent_m_p1;
  entry_t           ent_w_p2;
  reg_addr_t        e_rs_p0;
  reg_addr_t        e_rt_p0;
  reg_addr_t        m_rt_p1;
  logic             stall_d;
  logic [1:0]       fwd_d_rs_d;
  logic [1:0]       fwd_d_rt_d;
  logic [1:0]       fwd_e_rs_d;
  logic [1:0]       fwd_e_rt_d;
  logic [1:0]       fwd_m_rt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  // Register 0 and empty/bubble entries never produce a hazard.
  function automatic logic ent_match(input entry_t e, input reg_addr_t r);
    return e.valid && (e.dst != '0) && (e.dst == r);
  endfunction

  // Nearest producer decides: E first, then M. A producer in W has already
  // written its result into the pipeline and never causes a stall.
  function automatic logic op_stall(input reg_addr_t r, input logic [TW-1:0] tuse,
                                    input entry_t e, input entry_t m);
    if (tuse == TUSE_NONE) return 1'b0;
    if (ent_match(e, r))   return e.tnew > tuse;
    if (ent_match(m, r))   return m.tnew > tuse;
    return 1'b0;
  endfunction

  // M/W bypass select with M taking priority. A matching M entry that is not
  // yet ready still hides an older W copy, so a stale value is never picked.
  function automatic logic [1:0] near_sel(input reg_addr_t r, input entry_t m,
                                          input entry_t w);
    if (ent_match(m, r)) return (m.tnew == '0) ? FWD_M : FWD_RF;
    if (ent_match(w, r)) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : (c + CNT_W'(1));
  endfunction

  // D instruction as it would enter E when not stalled.
  always_comb begin
    d_ent       = '0;
    d_ent.valid = 1'b1;
    d_ent.dst   = bus.d_dst;
    d_ent.tnew  = bus.d_tnew;
  end

  // ---- D -> E boundary (p0): bubble inserted while stalled ----
  hazard_entry_reg u_ent_e (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d_ent),
    .bubble (stall_d),
    .dec    (1'b0),
    .q      (ent_e_p0)
  );

  // ---- E -> M boundary (p1): tnew ages by one ----
  hazard_entry_reg u_ent_m (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (ent_e_p0),
    .bubble (1'b0),
    .dec    (1'b1),
    .q      (ent_m_p1)
  );

  // ---- M -> W boundary (p2): tnew ages by one ----
  hazard_entry_reg u_ent_w (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (ent_m_p1),
    .bubble (1'b0),
    .dec    (1'b1),
    .q      (ent_w_p2)
  );

  // Source registers travelling with the E entry, and the store-data rt with M.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rs_p0 <= '0;
      e_rt_p0 <= '0;
      m_rt_p1 <= '0;
    end else begin
      e_rs_p0 <= stall_d ? '0 : bus.d_rs;
      e_rt_p0 <= stall_d ? '0 : bus.d_rt;
      m_rt_p1 <= e_rt_p0;
    end
  end

  // Stall decision and all bypass selects.
  always_comb begin
    stall_d    = op_stall(bus.d_rs, bus.d_tuse_rs, ent_e_p0, ent_m_p1) |
                 op_stall(bus.d_rt, bus.d_tuse_rt, ent_e_p0, ent_m_p1);
    // A producer still in E cannot be bypassed into D; stall covers it.
    fwd_d_rs_d = ent_match(ent_e_p0, bus.d_rs) ? FWD_RF
                                               : near_sel(bus.d_rs, ent_m_p1, ent_w_p2);
    fwd_d_rt_d = ent_match(ent_e_p0, bus.d_rt) ? FWD_RF
                                               : near_sel(bus.d_rt, ent_m_p1, ent_w_p2);
    fwd_e_rs_d = near_sel(e_rs_p0, ent_m_p1, ent_w_p2);
    fwd_e_rt_d = near_sel(e_rt_p0, ent_m_p1, ent_w_p2);
    fwd_m_rt_d = ent_match(ent_w_p2, m_rt_p1) ? FWD_W : FWD_RF;
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_d) begin
      stall_cnt_q <= cnt_inc_sat(stall_cnt_q);
    end
  end

  assign bus.stall     = stall_d;
  assign bus.fwd_d_rs  = fwd_d_rs_d;
  assign bus.fwd_d_rt  = fwd_d_rt_d;
  assign bus.fwd_e_rs  = fwd_e_rs_d;
  assign bus.fwd_e_rt  = fwd_e_rt_d;
  assign bus.fwd_m_rt  = fwd_m_rt_d;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: a D instruction is driven each cycle and the
// hand-derived outputs expected during that cycle are queued; a negedge
// process pops and compares them against the DUT.
module tb_hazard_fwd_ctrl;

  logic clk;
  logic rst_n;

  hazard_fwd_ctrl_if bus ();

  hazard_fwd_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic [1:0]  fdrs;
    logic [1:0]  fdrt;
    logic [1:0]  fers;
    logic [1:0]  fert;
    logic [1:0]  fmrt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_item = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic exp_t mk(input logic st, input logic [1:0] fdrs, input logic [1:0] fdrt,
                              input logic [1:0] fers, input logic [1:0] fert,
                              input logic [1:0] fmrt, input logic [31:0] cnt);
    exp_t e;
    e.stall = st; e.fdrs = fdrs; e.fdrt = fdrt;
    e.fers = fers; e.fert = fert; e.fmrt = fmrt; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t zero_exp(input logic [31:0] cnt);
    return mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, cnt);
  endfunction

  // Present one D instruction for one cycle and queue the outputs expected then.
  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] tur, input logic [1:0] tut,
                     input logic [4:0] dst, input logic [1:0] tnew, input exp_t e);
    @(posedge clk);
    #1;
    bus.d_rs = rs; bus.d_rt = rt;
    bus.d_tuse_rs = tur; bus.d_tuse_rt = tut;
    bus.d_dst = dst; bus.d_tnew = tnew;
    sb.push_back(e);
  endtask

  task automatic nop(input exp_t e);
    cyc(5'd0, 5'd0, 2'b11, 2'b11, 5'd0, 2'd0, e);
  endtask

  // Scoreboard consumer: compare every queued expectation mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      n_item++;
      chk_eq($sformatf("stall@%0d", n_item),     {31'd0, bus.stall}, {31'd0, cur.stall});
      chk_eq($sformatf("fwd_d_rs@%0d", n_item),  {30'd0, bus.fwd_d_rs}, {30'd0, cur.fdrs});
      chk_eq($sformatf("fwd_d_rt@%0d", n_item),  {30'd0, bus.fwd_d_rt}, {30'd0, cur.fdrt});
      chk_eq($sformatf("fwd_e_rs@%0d", n_item),  {30'd0, bus.fwd_e_rs}, {30'd0, cur.fers});
      chk_eq($sformatf("fwd_e_rt@%0d", n_item),  {30'd0, bus.fwd_e_rt}, {30'd0, cur.fert});
      chk_eq($sformatf("fwd_m_rt@%0d", n_item),  {30'd0, bus.fwd_m_rt}, {30'd0, cur.fmrt});
      chk_eq($sformatf("stall_cnt@%0d", n_item), bus.stall_cnt, cur.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.d_rs = '0; bus.d_rt = '0; bus.d_tuse_rs = '0; bus.d_tuse_rt = '0;
    bus.d_dst = '0; bus.d_tnew = '0;

    // reset held, then idle with all d_* = 0
    cyc(0, 0, 0, 0, 0, 0, zero_exp(0));
    #6 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, zero_exp(0));

    // addu $3 then reader of $3 (tuse 1): no stall, E bypass from M
    cyc(1, 2, 1, 1, 3, 1, zero_exp(0));
    cyc(3, 0, 1, 1, 4, 1, zero_exp(0));
    nop(mk(0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0));
    nop(zero_exp(0));
    nop(zero_exp(0));

    // lw $5 then beq on $5 with tuse 0: two stall cycles, then W bypass to D
    cyc(1, 0, 1, 3, 5, 2, zero_exp(0));
    cyc(5, 6, 0, 0, 0, 0, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    cyc(5, 6, 0, 0, 0, 0, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1));
    cyc(5, 6, 0, 0, 0, 0, mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2));
    nop(zero_exp(2));
    nop(zero_exp(2));

    // lw $5 then sw of $5 (tuse_rt 2): no stall, store data from W in M
    cyc(1, 0, 1, 3, 5, 2, zero_exp(2));
    cyc(1, 5, 1, 2, 0, 0, zero_exp(2));
    nop(zero_exp(2));
    nop(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2));
    nop(zero_exp(2));

    // two writers of $7 then a reader: youngest (M) wins over W
    cyc(1, 2, 1, 1, 7, 1, zero_exp(2));
    cyc(1, 2, 1, 1, 7, 1, zero_exp(2));
    cyc(7, 0, 1, 1, 8, 1, zero_exp(2));
    nop(mk(0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2));
    nop(zero_exp(2));
    nop(zero_exp(2));

    // addu $9, gap, beq on rt=$9: D bypass from M, then E rt bypass from W
    cyc(1, 2, 1, 1, 9, 1, zero_exp(2));
    nop(zero_exp(2));
    cyc(2, 9, 0, 0, 0, 0, mk(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2));
    nop(mk(0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2));
    nop(zero_exp(2));

    // writer of $0 then reader of $0: never a hazard
    cyc(1, 0, 1, 3, 0, 2, zero_exp(2));
    cyc(0, 0, 0, 0, 0, 0, zero_exp(2));
    nop(zero_exp(2));

    // D reads and writes $10: no self-hazard
    cyc(10, 10, 0, 0, 10, 2, zero_exp(2));
    nop(zero_exp(2));
    nop(zero_exp(2));

    // lw $11 then user with tuse 1: exactly one stall, then E bypass from W
    cyc(1, 0, 1, 3, 11, 2, zero_exp(2));
    cyc(11, 0, 1, 1, 12, 1, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2));
    cyc(11, 0, 1, 1, 12, 1, zero_exp(3));
    nop(mk(0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 3));
    nop(zero_exp(3));

    // lw $13 then user with tuse 0; reset asserted in the middle of the stall
    cyc(1, 0, 1, 3, 13, 2, zero_exp(3));
    cyc(13, 0, 0, 3, 0, 0, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3));
    @(posedge clk);
    #1;
    chk_eq("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
    chk_eq("pre_rst_cnt", bus.stall_cnt, 32'd4);
    #1 rst_n = 1'b0;
    sb.push_back(zero_exp(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    // same D instruction after release sees an empty scoreboard
    cyc(13, 0, 0, 3, 0, 0, zero_exp(0));

    repeat (2) @(negedge clk);
    #1;
    chk_eq("sb_drain", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
